// File: rtl/mux_nx1_rr_pkg.sv
// Shared encodings and helpers for the registered N-to-1 round-robin mux.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Per-channel producer handshakes plus the single registered output stream.
interface mux_nx1_rr_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int SELW = mux_pkg::clog2_min1(N_CH)
);
    logic [N_CH*DW-1:0] in_data;
    logic [N_CH-1:0]    in_valid;
    logic [N_CH-1:0]    in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [DW-1:0]      out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_nx1_rr_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping mod N_CH.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arb #(
    parameter int N_CH = 4,
    parameter int SELW = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);
    int k;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k       = 0;
        for (int i = 0; i < N_CH; i++) begin
            // Wrap against N_CH, not 2^SELW, so non-power-of-2 counts work.
            k = int'(ptr) + i;
            if (k >= N_CH) k = k - N_CH;
            if (!gnt_vld && req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = SELW'(k);
            end
        end
    end
endmodule

// File: rtl/mux_nx1_rr.sv
// N-to-1 mux, fixed-select or round-robin, with one registered output stage.
// Latency: 1 clk from input accept to out_valid; 1 word/clk sustained.
// Backpressure: held word stays stable and all in_ready drop while out_ready is low.
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_nx1_rr_if.slave  bus
);
    localparam int SELW = clog2_min1(N_CH);

    state_t            state_q, state_d;
    logic [DW-1:0]     out_data_q;
    logic [SELW-1:0]   out_ch_q;
    logic [SELW-1:0]   rr_ptr_q;

    logic              arb_vld;
    logic [SELW-1:0]   arb_idx;
    logic              grant_vld;
    logic [SELW-1:0]   grant_idx;
    logic [DW-1:0]     grant_dat;
    logic              load;
    logic              accept;
    logic [N_CH-1:0]   in_ready_c;

    rr_arb #(.N_CH(N_CH), .SELW(SELW)) u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_q),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_dat  = '0;
        in_ready_c = '0;
        state_d    = state_q;

        if (bus.mode == MODE_RR) begin
            grant_vld = arb_vld;
            grant_idx = arb_idx;
        end else begin
            // Out-of-range sel matches no channel and so never grants.
            for (int c = 0; c < N_CH; c++) begin
                if (bus.sel == SELW'(c) && bus.in_valid[c]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(c);
                end
            end
        end

        for (int c = 0; c < N_CH; c++) begin
            if (grant_idx == SELW'(c)) grant_dat = bus.in_data[c*DW +: DW];
        end

        load   = (state_q == ST_EMPTY) || bus.out_ready;
        accept = load && grant_vld && rst_n;

        for (int c = 0; c < N_CH; c++) begin
            in_ready_c[c] = accept && (grant_idx == SELW'(c));
        end

        if (accept)             state_d = ST_FULL;
        else if (bus.out_ready) state_d = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_ch_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_data_q <= grant_dat;
                out_ch_q   <= grant_idx;
                rr_ptr_q   <= (grant_idx == SELW'(N_CH - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed vector bench for mux_nx1_rr with N_CH=4, DW=8.
module tb_mux_nx1_rr;
    logic clk;
    logic rst_n;

    mux_nx1_rr_if #(.N_CH(4), .DW(8)) bus ();

    mux_nx1_rr #(.N_CH(4), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        ordy;
        logic [31:0] dat;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic        chk;
        logic [1:0]  e_ch;
        logic [7:0]  e_dat;
    } vec_t;

    localparam logic [31:0] DAT_DEF = {8'h13, 8'h12, 8'h11, 8'h10};
    localparam logic [31:0] DAT_A5  = {8'h13, 8'hA5, 8'h11, 8'h10};
    localparam logic [31:0] DAT_3C  = {8'h13, 8'h12, 8'h11, 8'h3C};

    int checks;
    int errors;
    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic m, input logic [1:0] s,
                               input logic [3:0] iv, input logic ordy, input logic [31:0] d,
                               input logic [3:0] e_rdy, input logic e_vld, input logic chk,
                               input logic [1:0] e_ch, input logic [7:0] e_dat);
        vec_t x;
        x.rst_n = r;  x.mode = m;   x.sel = s;     x.iv = iv;   x.ordy = ordy; x.dat = d;
        x.e_rdy = e_rdy; x.e_vld = e_vld; x.chk = chk; x.e_ch = e_ch; x.e_dat = e_dat;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive on the falling edge, check in_ready combinationally, then the registered result.
    task automatic step(input vec_t x, input int idx);
        @(negedge clk);
        rst_n        = x.rst_n;
        bus.mode     = x.mode;
        bus.sel      = x.sel;
        bus.in_valid = x.iv;
        bus.out_ready = x.ordy;
        bus.in_data  = x.dat;
        #1;
        check("in_ready", idx, 32'(bus.in_ready), 32'(x.e_rdy));
        @(posedge clk);
        #1;
        check("out_valid", idx, 32'(bus.out_valid), 32'(x.e_vld));
        if (x.chk) begin
            check("out_ch", idx, 32'(bus.out_ch), 32'(x.e_ch));
            check("out_data", idx, 32'(bus.out_data), 32'(x.e_dat));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.mode = 1'b0;
        bus.sel = '0;
        bus.in_valid = '0;
        bus.out_ready = 1'b0;
        bus.in_data = '0;

        // Reset held 3 clk with every channel requesting.
        for (int i = 0; i < 3; i++)
            step(v(0, 1, 0, 4'b1111, 1, DAT_DEF, 4'b0000, 0, 1, 2'd0, 8'h00), i);

        // FIXED grant / miss, RR sweeps, wrap with sparse requests, backpressure.
        tbl.push_back(v(1, 0, 2, 4'b0100, 1, DAT_A5,  4'b0100, 1, 1, 2'd2, 8'hA5));
        tbl.push_back(v(1, 0, 3, 4'b0100, 1, DAT_A5,  4'b0000, 0, 0, 2'd0, 8'h00));
        tbl.push_back(v(1, 0, 3, 4'b0100, 1, DAT_A5,  4'b0000, 0, 0, 2'd0, 8'h00));
        tbl.push_back(v(1, 0, 3, 4'b1000, 1, DAT_DEF, 4'b1000, 1, 1, 2'd3, 8'h13));
        tbl.push_back(v(1, 1, 0, 4'b1111, 1, DAT_DEF, 4'b0001, 1, 1, 2'd0, 8'h10));
        tbl.push_back(v(1, 1, 0, 4'b1111, 1, DAT_DEF, 4'b0010, 1, 1, 2'd1, 8'h11));
        tbl.push_back(v(1, 1, 0, 4'b1111, 1, DAT_DEF, 4'b0100, 1, 1, 2'd2, 8'h12));
        tbl.push_back(v(1, 1, 0, 4'b1111, 1, DAT_DEF, 4'b1000, 1, 1, 2'd3, 8'h13));
        tbl.push_back(v(1, 1, 0, 4'b1111, 1, DAT_DEF, 4'b0001, 1, 1, 2'd0, 8'h10));
        tbl.push_back(v(1, 1, 0, 4'b1111, 1, DAT_DEF, 4'b0010, 1, 1, 2'd1, 8'h11));
        tbl.push_back(v(1, 1, 0, 4'b1000, 1, DAT_DEF, 4'b1000, 1, 1, 2'd3, 8'h13));
        tbl.push_back(v(1, 1, 0, 4'b1010, 1, DAT_DEF, 4'b0010, 1, 1, 2'd1, 8'h11));
        tbl.push_back(v(1, 1, 0, 4'b1010, 1, DAT_DEF, 4'b1000, 1, 1, 2'd3, 8'h13));
        tbl.push_back(v(1, 1, 0, 4'b1010, 1, DAT_DEF, 4'b0010, 1, 1, 2'd1, 8'h11));
        tbl.push_back(v(1, 1, 0, 4'b1010, 1, DAT_DEF, 4'b1000, 1, 1, 2'd3, 8'h13));
        tbl.push_back(v(1, 1, 0, 4'b0000, 1, DAT_DEF, 4'b0000, 0, 0, 2'd0, 8'h00));
        tbl.push_back(v(1, 0, 0, 4'b0001, 1, DAT_3C,  4'b0001, 1, 1, 2'd0, 8'h3C));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1, 1, 0, 4'b0010, 0, DAT_DEF, 4'b0000, 1, 1, 2'd0, 8'h3C));
        tbl.push_back(v(1, 1, 0, 4'b0010, 1, DAT_DEF, 4'b0010, 1, 1, 2'd1, 8'h11));

        foreach (tbl[i]) step(tbl[i], 10 + i);

        // Reset while FULL in RR: word dropped, pointer back at ch0.
        step(v(0, 1, 0, 4'b1111, 1, DAT_DEF, 4'b0000, 0, 1, 2'd0, 8'h00), 100);
        step(v(1, 1, 0, 4'b1111, 1, DAT_DEF, 4'b0001, 1, 1, 2'd0, 8'h10), 101);
        // Switch to FIXED sel=1 while the word is held.
        step(v(1, 0, 1, 4'b0010, 0, DAT_DEF, 4'b0000, 1, 1, 2'd0, 8'h10), 102);
        step(v(1, 0, 1, 4'b0010, 0, DAT_DEF, 4'b0000, 1, 1, 2'd0, 8'h10), 103);
        step(v(1, 0, 1, 4'b0010, 1, DAT_DEF, 4'b0010, 1, 1, 2'd1, 8'h11), 104);
        step(v(1, 0, 1, 4'b0000, 1, DAT_DEF, 4'b0000, 0, 0, 2'd0, 8'h00), 105);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
